// File: rtl/ps2_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_transmitter
//  Purpose  : Host-to-device PS/2 command transmitter (inhibit, request-to-send,
//             11-bit frame on device clock, ACK check, frame timeout).
//  Revision : 1.0  initial release
// ============================================================================
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int RTS_CYCLES     = 200,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILT_CYCLES    = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int c_PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX + 1) : 1;
    localparam int c_TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_FILT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES + 1) : 1;

    localparam logic [c_PH_W-1:0]   c_INH_LAST  = c_PH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_PH_W-1:0]   c_RTS_LAST  = c_PH_W'(RTS_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILT_CYCLES - 1);

    localparam logic [1:0] c_ERR_OK   = 2'b00;
    localparam logic [1:0] c_ERR_NACK = 2'b01;
    localparam logic [1:0] c_ERR_TMO  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: bit 0 = kclk, bit 1 = kdata
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {kdata, kclk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic                r_s1;
            logic                r_s2;
            logic                r_f;
            logic [c_FILT_W-1:0] r_fcnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s1   <= 1'b1;
                    r_s2   <= 1'b1;
                    r_f    <= 1'b1;
                    r_fcnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_f) begin
                        r_fcnt <= '0;
                    end else if (r_fcnt == c_FILT_LAST) begin
                        r_f    <= r_s2;
                        r_fcnt <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_f;
        end
    endgenerate

    logic r_kclk_prev;
    logic w_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kclk_prev <= 1'b1;
        end else begin
            r_kclk_prev <= w_filt[0];
        end
    end

    assign w_fall = r_kclk_prev & ~w_filt[0];

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t              r_state,    w_state_nx;
    logic [c_PH_W-1:0]   r_cnt,      w_cnt_nx;
    logic [c_TMO_W-1:0]  r_tcnt,     w_tcnt_nx;
    logic [3:0]          r_bitidx,   w_bitidx_nx;
    logic [7:0]          r_data,     w_data_nx;
    logic                r_par,      w_par_nx;
    logic                r_nack,     w_nack_nx;
    logic                r_kclk_oe,  w_kclk_oe_nx;
    logic                r_kdata_oe, w_kdata_oe_nx;
    logic                r_done,     w_done_nx;
    logic [1:0]          r_err,      w_err_nx;
    logic                w_in_frame;
    logic                w_timeout;

    assign w_in_frame = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout  = w_in_frame && (r_tcnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_tcnt     <= '0;
            r_bitidx   <= '0;
            r_data     <= '0;
            r_par      <= 1'b0;
            r_nack     <= 1'b0;
            r_kclk_oe  <= 1'b0;
            r_kdata_oe <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= c_ERR_OK;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_tcnt     <= w_tcnt_nx;
            r_bitidx   <= w_bitidx_nx;
            r_data     <= w_data_nx;
            r_par      <= w_par_nx;
            r_nack     <= w_nack_nx;
            r_kclk_oe  <= w_kclk_oe_nx;
            r_kdata_oe <= w_kdata_oe_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_tcnt_nx     = r_tcnt;
        w_bitidx_nx   = r_bitidx;
        w_data_nx     = r_data;
        w_par_nx      = r_par;
        w_nack_nx     = r_nack;
        w_kclk_oe_nx  = r_kclk_oe;
        w_kdata_oe_nx = r_kdata_oe;
        w_done_nx     = 1'b0;
        w_err_nx      = c_ERR_OK;

        case (r_state)
            S_IDLE: begin
                w_kclk_oe_nx  = 1'b0;
                w_kdata_oe_nx = 1'b0;
                if (tx_valid) begin
                    w_data_nx    = tx_data;
                    w_par_nx     = ~^tx_data;
                    w_nack_nx    = 1'b0;
                    w_cnt_nx     = '0;
                    w_kclk_oe_nx = 1'b1;
                    w_state_nx   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (r_cnt == c_INH_LAST) begin
                    w_cnt_nx      = '0;
                    w_kdata_oe_nx = 1'b1;
                    w_state_nx    = S_RTS;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            S_RTS: begin
                if (r_cnt == c_RTS_LAST) begin
                    w_kclk_oe_nx = 1'b0;
                    w_bitidx_nx  = '0;
                    w_tcnt_nx    = '0;
                    w_state_nx   = S_SEND;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            S_SEND: begin
                w_tcnt_nx = r_tcnt + 1'b1;
                if (w_fall) begin
                    w_bitidx_nx = r_bitidx + 4'd1;
                    // r_bitidx counts falls already seen, so it indexes the next data bit
                    if (r_bitidx < 4'd8) begin
                        w_kdata_oe_nx = ~r_data[r_bitidx[2:0]];
                    end else if (r_bitidx == 4'd8) begin
                        w_kdata_oe_nx = ~r_par;
                    end else begin
                        w_kdata_oe_nx = 1'b0;
                        w_state_nx    = S_ACK;
                    end
                end
            end

            S_ACK: begin
                w_tcnt_nx = r_tcnt + 1'b1;
                if (w_fall) begin
                    w_nack_nx  = w_filt[1];
                    w_state_nx = S_WAIT_IDLE;
                end
            end

            S_WAIT_IDLE: begin
                w_tcnt_nx = r_tcnt + 1'b1;
                if (w_filt[0] && w_filt[1]) begin
                    w_done_nx  = 1'b1;
                    w_err_nx   = r_nack ? c_ERR_NACK : c_ERR_OK;
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_kclk_oe_nx  = 1'b0;
                w_kdata_oe_nx = 1'b0;
                w_state_nx    = S_IDLE;
            end
        endcase

        // Timeout overrides any same-cycle fall or line-idle completion
        if (w_timeout) begin
            w_kclk_oe_nx  = 1'b0;
            w_kdata_oe_nx = 1'b0;
            w_done_nx     = 1'b1;
            w_err_nx      = c_ERR_TMO;
            w_state_nx    = S_IDLE;
        end
    end

    assign tx_ready = (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign kclk_oe  = r_kclk_oe;
    assign kdata_oe = r_kdata_oe;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_transmitter
//  Purpose  : Self-checking bench for ps2_transmitter with a PS/2 device model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_transmitter;

    localparam int INH = 100;
    localparam int RTS = 4;
    localparam int TMO = 500;
    localparam int FLT = 3;
    localparam int HI  = 12;
    localparam int LO  = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       kclk_oe;
    logic       kdata_oe;
    logic       busy;
    logic       done;
    logic [1:0] err;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic kclk_line;
    logic kdata_line;

    // Open-collector bus: either side pulling low wins
    assign kclk_line  = ~kclk_oe  & ~dev_clk_low;
    assign kdata_line = ~kdata_oe & ~dev_data_low;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_transmitter #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO),
        .FILT_CYCLES    (FLT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .kclk     (kclk_line),
        .kdata    (kdata_line),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame as the device should see it: bit0 start .. bit10 stop
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Accept a byte, keep requesting a different byte while busy, and measure oe timing
    task automatic start_tx(input logic [7:0] b, output int oe_cyc, output int rts_first,
                            output int rts_cyc);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data   = ~b;
        oe_cyc    = 0;
        rts_cyc   = 0;
        rts_first = -1;
        while (kclk_oe && oe_cyc < INH + RTS + 50) begin
            if (kdata_oe) begin
                if (rts_first < 0) rts_first = oe_cyc;
                rts_cyc++;
            end
            oe_cyc++;
            if (oe_cyc == 5) tx_valid = 1'b0;
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    // One device clock period; samples the data line just after the rising edge
    task automatic dev_bit(input bit drive_ack, input bit glitch, output logic smp);
        for (int k = 0; k < HI; k++) begin
            if (glitch && k == 3) dev_clk_low = 1'b1;
            if (glitch && k == 5) dev_clk_low = 1'b0;
            if (drive_ack && k == HI / 2) dev_data_low = 1'b1;
            @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (LO) @(negedge clk);
        dev_clk_low = 1'b0;
        @(negedge clk);
        smp = kdata_line;
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input bit glitch,
                             output logic [10:0] bits, output logic [1:0] e,
                             output bit got, output bit rdy, output bit idle_ok,
                             output int oe_cyc, output int rts_first, output int rts_cyc);
        logic s;
        start_tx(b, oe_cyc, rts_first, rts_cyc);
        bits    = '0;
        bits[0] = kdata_line;
        for (int i = 1; i <= 11; i++) begin
            dev_bit(ack && (i == 11), glitch && (i == 3), s);
            if (i <= 10) bits[i] = s;
        end
        got     = 1'b0;
        rdy     = 1'b0;
        idle_ok = 1'b0;
        e       = 2'b11;
        for (int k = 0; k < 100 && !got; k++) begin
            if (k == 3) dev_data_low = 1'b0;
            if (done) begin
                got     = 1'b1;
                e       = err;
                rdy     = tx_ready;
                idle_ok = !kclk_oe && !kdata_oe && !busy;
            end
            @(negedge clk);
        end
        dev_data_low = 1'b0;
        check("done_single_pulse", done, 1'b0);
        check("err_zero_after_done", err, 2'b00);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         glitch;
        bit         par;
        logic [1:0] err;
    } vec_t;

    vec_t vecs[4];

    task automatic frame_checks(input string tag, input logic [10:0] exp_bits,
                                input logic [1:0] exp_err, input logic [7:0] b,
                                input bit ack, input bit glitch);
        logic [10:0] bits;
        logic [1:0]  e;
        bit          got, rdy, idle_ok;
        int          oe_cyc, rts_first, rts_cyc;
        run_frame(b, ack, glitch, bits, e, got, rdy, idle_ok, oe_cyc, rts_first, rts_cyc);
        check({tag, "_kclk_oe_cycles"}, oe_cyc, INH + RTS);
        check({tag, "_kdata_oe_cycles"}, rts_cyc, RTS);
        check({tag, "_kdata_oe_start"}, rts_first, INH);
        check({tag, "_frame_bits"}, bits, exp_bits);
        check({tag, "_done_seen"}, got, 1'b1);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_ready_at_done"}, rdy, 1'b1);
        check({tag, "_lines_released"}, idle_ok, 1'b1);
    endtask

    initial begin
        int    t;
        int    ndone;
        int    oe_cyc, rts_first, rts_cyc;
        logic  s;
        logic [7:0] rb;
        bit    rack;

        vecs[0] = '{data: 8'hED, ack: 1'b1, glitch: 1'b0, par: 1'b1, err: 2'b00};
        vecs[1] = '{data: 8'h01, ack: 1'b1, glitch: 1'b0, par: 1'b0, err: 2'b00};
        vecs[2] = '{data: 8'h55, ack: 1'b0, glitch: 1'b0, par: 1'b1, err: 2'b01};
        vecs[3] = '{data: 8'hFF, ack: 1'b1, glitch: 1'b1, par: 1'b1, err: 2'b00};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_kclk_oe", kclk_oe, 1'b0);
        check("rst_kdata_oe", kdata_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 2'b00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Directed frames from the table
        for (int i = 0; i < 4; i++) begin
            frame_checks($sformatf("vec%0d", i), {1'b1, vecs[i].par, vecs[i].data, 1'b0},
                         vecs[i].err, vecs[i].data, vecs[i].ack, vecs[i].glitch);
            repeat (5) @(negedge clk);
        end

        // Timeout: device never clocks after the host releases kclk
        start_tx(8'h3C, oe_cyc, rts_first, rts_cyc);
        check("tmo_kclk_oe_cycles", oe_cyc, INH + RTS);
        t = 0;
        while (!done && t < 2 * TMO) begin
            @(negedge clk);
            t++;
        end
        check("tmo_latency", t, TMO);
        check("tmo_err", err, 2'b10);
        check("tmo_kclk_oe", kclk_oe, 1'b0);
        check("tmo_kdata_oe", kdata_oe, 1'b0);
        check("tmo_busy", busy, 1'b0);
        check("tmo_ready", tx_ready, 1'b1);
        repeat (5) @(negedge clk);

        // Reset in the middle of a frame, while the device holds clock low at fall 5
        start_tx(8'hA5, oe_cyc, rts_first, rts_cyc);
        for (int i = 1; i <= 4; i++) dev_bit(1'b0, 1'b0, s);
        repeat (HI) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_kdata_oe_before_rst", kdata_oe, 1'b1);
        check("mid_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_kclk_oe", kclk_oe, 1'b0);
        check("mid_rst_kdata_oe", kdata_oe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("post_rst_no_done", ndone, 0);
        check("post_rst_ready", tx_ready, 1'b1);
        frame_checks("after_rst", model_frame(8'hF4), 2'b00, 8'hF4, 1'b1, 1'b0);
        repeat (5) @(negedge clk);

        // Randomized frames against the reference model
        for (int i = 0; i < 4; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            frame_checks($sformatf("rnd%0d_%02h", i, rb), model_frame(rb),
                         rack ? 2'b00 : 2'b01, rb, rack, 1'b0);
            repeat (5) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
